// File: rtl/nibble_link_tx_if.sv
// nibble_link_tx_if: word-side valid/ready and link-side nibble/send/ack signals of the nibble transmitter
interface nibble_link_tx_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [3:0]  nibble_o;
  logic        send_o;
  logic        ack_i;
  modport master (output in_valid, in_data, ack_i, input in_ready, nibble_o, send_o);
  modport slave  (input in_valid, in_data, ack_i, output in_ready, nibble_o, send_o);
endinterface

// File: rtl/nibble_link_tx.sv
// nibble_link_tx: sends 32-bit words as 8 send/ack nibbles LSB first; NIBBLE_TX_TIMEOUT_EN adds an ack watchdog
module nibble_link_tx #(
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  nibble_link_tx_if.slave lnk,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);
  localparam int unsigned TMAX = GAP_CYCLES > HOLDOFF_CYCLES ? GAP_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP, HOLDOFF} state_t;
  state_t        state;
  logic [31:0]   shreg;
  logic [2:0]    cnt;
  logic [TW-1:0] tmr;
  logic          timeout;
  if (GAP_CYCLES < 1 || HOLDOFF_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
    $error("nibble_link_tx: GAP_CYCLES, HOLDOFF_CYCLES and ACK_TIMEOUT must all be >= 1");
  end
  assign lnk.in_ready = state == IDLE;
  assign busy_o       = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      tmr          <= '0;
      lnk.nibble_o <= '0;
      lnk.send_o   <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (lnk.in_valid) begin
          shreg        <= lnk.in_data;
          cnt          <= '0;
          lnk.nibble_o <= lnk.in_data[3:0];
          lnk.send_o   <= 1'b1;
          state        <= SEND;
        end
        SEND: if (lnk.ack_i) begin
          lnk.send_o <= 1'b0;
          shreg      <= shreg >> 4;
          if (cnt == 3'd7) begin
            tmr   <= TW'(HOLDOFF_CYCLES);
            state <= HOLDOFF;
          end else begin
            cnt   <= cnt + 3'd1;
            tmr   <= TW'(GAP_CYCLES);
            state <= GAP;
          end
        end else if (timeout) begin
          lnk.send_o <= 1'b0;
          state      <= IDLE;
        end
        // shreg was already shifted on the ack, so its low nibble is the next one to send
        GAP: if (tmr == TW'(1)) begin
          lnk.nibble_o <= shreg[3:0];
          lnk.send_o   <= 1'b1;
          state        <= SEND;
        end else tmr <= tmr - 1'b1;
        HOLDOFF: if (tmr == TW'(1)) begin
          done_o <= 1'b1;
          state  <= IDLE;
        end else tmr <= tmr - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef NIBBLE_TX_TIMEOUT_EN
  localparam int unsigned WW = $clog2(ACK_TIMEOUT + 1);
  logic [WW-1:0] wd;
  assign timeout = state == SEND && !lnk.ack_i && wd == WW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd    <= '0;
      err_o <= 1'b0;
    end else begin
      wd    <= state == SEND && !lnk.ack_i && !timeout ? wd + 1'b1 : '0;
      err_o <= err_o | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif
endmodule
